// File: rtl/uart_tx_serializer_if.sv
// UART TX parallel-side bundle: request word/config in, serial line and busy out.
// Latency: none (wires only).
// Backpressure: busy tells the master that a new Data_Valid is ignored until the frame ends.
interface uart_tx_serializer_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int PRESC_WIDTH = 5
);
    logic [DATA_WIDTH-1:0]  P_DATA;
    logic                   Data_Valid;
    logic                   PAR_EN;
    logic                   PAR_TYP;
    logic [PRESC_WIDTH-1:0] Prescale;
    logic                   TX_OUT;
    logic                   busy;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
        input  TX_OUT, busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
        output TX_OUT, busy
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start, DATA_WIDTH bits LSB-first, optional parity, stop; Prescale clocks per bit.
// Latency: start bit appears on TX_OUT at the accepting edge (registered, 0 extra cycles).
// Backpressure: Data_Valid only accepted when idle or at the last stop-bit cycle; otherwise dropped.
module uart_tx_serializer #(
    parameter int DATA_WIDTH  = 8,
    parameter int PRESC_WIDTH = 5
) (
    input  logic                 CLK,
    input  logic                 RST,
    uart_tx_serializer_if.slave  tx_if
);

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BCW-1:0]         LAST_BIT   = BCW'(DATA_WIDTH - 1);
    localparam logic [PRESC_WIDTH-1:0] PRESC_MIN  = PRESC_WIDTH'(4);
    localparam logic [PRESC_WIDTH-1:0] PRESC_DFLT = PRESC_WIDTH'(8);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                 state_q,    state_d;
    logic [PRESC_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic [BCW-1:0]         bit_cnt_q,  bit_cnt_d;
    logic [DATA_WIDTH-1:0]  data_q,     data_d;
    logic                   par_en_q,   par_en_d;
    logic                   par_typ_q,  par_typ_d;
    logic [PRESC_WIDTH-1:0] presc_q,    presc_d;
    logic                   tx_q,       tx_d;
    logic                   busy_q,     busy_d;

    logic                   bit_end;
    logic                   parity_bit;
    logic                   accept;
    logic [BCW-1:0]         bit_nxt;

    assign bit_end    = (edge_cnt_q == (presc_q - 1'b1));
    assign parity_bit = par_typ_q ? ~^data_q : ^data_q;
    assign bit_nxt    = bit_cnt_q + 1'b1;

    assign tx_if.TX_OUT = tx_q;
    assign tx_if.busy   = busy_q;

    // Next-state, bit timing and next serial-line value.
    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        data_d     = data_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        presc_d    = presc_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        accept     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_d       = 1'b1;
                busy_d     = 1'b0;
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
                accept     = tx_if.Data_Valid;
            end
            ST_START: begin
                if (bit_end) begin
                    edge_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = ST_DATA;
                    tx_d       = data_q[0];
                end else begin
                    edge_cnt_d = edge_cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    edge_cnt_d = '0;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        if (par_en_q) begin
                            state_d = ST_PARITY;
                            tx_d    = parity_bit;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_nxt;
                        tx_d      = data_q[bit_nxt];
                    end
                end else begin
                    edge_cnt_d = edge_cnt_q + 1'b1;
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    edge_cnt_d = '0;
                    state_d    = ST_STOP;
                    tx_d       = 1'b1;
                end else begin
                    edge_cnt_d = edge_cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    edge_cnt_d = '0;
                    if (tx_if.Data_Valid) begin
                        // Back-to-back word: next start bit follows with no idle gap.
                        accept = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else begin
                    edge_cnt_d = edge_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                tx_d       = 1'b1;
                busy_d     = 1'b0;
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
            end
        endcase

        // Snapshot word and config so later input changes cannot disturb this frame.
        if (accept) begin
            data_d     = tx_if.P_DATA;
            par_en_d   = tx_if.PAR_EN;
            par_typ_d  = tx_if.PAR_TYP;
            presc_d    = (tx_if.Prescale < PRESC_MIN) ? PRESC_DFLT : tx_if.Prescale;
            state_d    = ST_START;
            tx_d       = 1'b0;
            busy_d     = 1'b1;
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
        end
    end

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            presc_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            data_q     <= data_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            presc_q    <= presc_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: directed frames, expected line levels queued per bit.
// Latency: monitor aligns on busy rising after a queued frame.
// Backpressure: stimulus waits for the scoreboard to drain before the next test.
module tb_uart_tx_serializer;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    uart_tx_serializer_if #(.DATA_WIDTH(8), .PRESC_WIDTH(5)) dut_if ();

    uart_tx_serializer #(.DATA_WIDTH(8), .PRESC_WIDTH(5)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .tx_if (dut_if.slave)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic val;
        logic bsy;
        int   len;
        int   idx;
    } item_t;

    item_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    bit    mon_active = 1'b0;
    int    item_seq = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Push one expected line level per transmitted bit; bits given in wire order.
    task automatic push_frame(input string bits, input int p);
        item_t it;
        for (int i = 0; i < bits.len(); i++) begin
            it.val = (bits[i] == 8'h31);
            it.bsy = 1'b1;
            it.len = p;
            it.idx = item_seq++;
            exp_q.push_back(it);
        end
    endtask

    task automatic push_idle();
        item_t it;
        it.val = 1'b1;
        it.bsy = 1'b0;
        it.len = 1;
        it.idx = item_seq++;
        exp_q.push_back(it);
    endtask

    task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [4:0] ps);
        @(negedge CLK);
        dut_if.P_DATA     = d;
        dut_if.PAR_EN     = pe;
        dut_if.PAR_TYP    = pt;
        dut_if.Prescale   = ps;
        dut_if.Data_Valid = 1'b1;
        @(negedge CLK);
        dut_if.Data_Valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while ((exp_q.size() > 0 || mon_active) && t < 3000) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 3000) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s timeout: %0d items still expected", name, exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge CLK);
    endtask

    // Monitor: once busy rises with work queued, each item must hold for len cycles.
    initial begin
        item_t it;
        bit    first;
        bit    ok;
        logic  got_tx;
        logic  got_busy;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0 && dut_if.busy === 1'b1) begin
                mon_active = 1'b1;
                first = 1'b1;
                while (exp_q.size() > 0) begin
                    it = exp_q.pop_front();
                    ok = 1'b1;
                    got_tx = it.val;
                    got_busy = it.bsy;
                    for (int c = 0; c < it.len; c++) begin
                        if (!first) @(negedge CLK);
                        first = 1'b0;
                        if (dut_if.TX_OUT !== it.val || dut_if.busy !== it.bsy) begin
                            if (ok) begin
                                got_tx = dut_if.TX_OUT;
                                got_busy = dut_if.busy;
                            end
                            ok = 1'b0;
                        end
                    end
                    n_cmp++;
                    if (!ok) begin
                        n_err++;
                        $display("FAIL item%0d: got tx=%b busy=%b expected tx=%b busy=%b for %0d cycles",
                                 it.idx, got_tx, got_busy, it.val, it.bsy, it.len);
                    end
                end
                mon_active = 1'b0;
            end
        end
    end

    initial begin
        bit quiet;
        dut_if.P_DATA     = '0;
        dut_if.Data_Valid = 1'b0;
        dut_if.PAR_EN     = 1'b0;
        dut_if.PAR_TYP    = 1'b0;
        dut_if.Prescale   = 5'd8;

        #1 RST = 1'b0;
        #1;
        check("reset_tx", {31'd0, dut_if.TX_OUT}, 32'd1);
        check("reset_busy", {31'd0, dut_if.busy}, 32'd0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;

        // Mid-frame reset: frame started without expectations, then aborted.
        send(8'hA5, 1'b1, 1'b0, 5'd8);
        repeat (20) @(negedge CLK);
        check("midframe_busy", {31'd0, dut_if.busy}, 32'd1);
        check("midframe_tx_bit1", {31'd0, dut_if.TX_OUT}, 32'd0);
        #2 RST = 1'b0;
        #1;
        check("async_reset_tx", {31'd0, dut_if.TX_OUT}, 32'd1);
        check("async_reset_busy", {31'd0, dut_if.busy}, 32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (dut_if.TX_OUT !== 1'b1 || dut_if.busy !== 1'b0) quiet = 1'b0;
        end
        check("post_reset_quiet", {31'd0, quiet}, 32'd1);

        // 0xA5 even parity, 8 cycles per bit: 88 busy cycles.
        push_frame("01010010101", 8);
        push_idle();
        send(8'hA5, 1'b1, 1'b0, 5'd8);
        wait_drain("a5_even_p8");

        // 0xA5 odd parity, 16 cycles per bit: 176 busy cycles.
        push_frame("01010010111", 16);
        push_idle();
        send(8'hA5, 1'b1, 1'b1, 5'd16);
        wait_drain("a5_odd_p16");

        // 0x3C no parity; a stray 0xFF request mid-frame must be dropped.
        push_frame("0001111001", 8);
        push_idle();
        send(8'h3C, 1'b0, 1'b0, 5'd8);
        repeat (28) @(negedge CLK);
        dut_if.P_DATA     = 8'hFF;
        dut_if.PAR_EN     = 1'b1;
        dut_if.Data_Valid = 1'b1;
        @(negedge CLK);
        dut_if.Data_Valid = 1'b0;
        wait_drain("3c_ignore_ff");

        // Back-to-back 0x55 then 0x0F with Data_Valid held: no idle gap.
        push_frame("0101010101", 8);
        @(negedge CLK);
        dut_if.P_DATA     = 8'h55;
        dut_if.PAR_EN     = 1'b0;
        dut_if.PAR_TYP    = 1'b0;
        dut_if.Prescale   = 5'd8;
        dut_if.Data_Valid = 1'b1;
        @(negedge CLK);
        dut_if.P_DATA = 8'h0F;
        push_frame("0111100001", 8);
        push_idle();
        repeat (84) @(negedge CLK);
        dut_if.Data_Valid = 1'b0;
        wait_drain("b2b_55_0f");

        // Prescale 2 latched as 8; a mid-frame change to 16 has no effect.
        push_frame("01000000111", 8);
        push_idle();
        send(8'h81, 1'b1, 1'b1, 5'd2);
        repeat (30) @(negedge CLK);
        dut_if.Prescale = 5'd16;
        wait_drain("presc2_as8");

        // Prescale 3 is also below the legal floor.
        push_frame("01111111111", 8);
        push_idle();
        send(8'hFF, 1'b1, 1'b1, 5'd3);
        wait_drain("presc3_as8");

        // Prescale 4 is the smallest value used as-is.
        push_frame("00000000001", 4);
        push_idle();
        send(8'h00, 1'b1, 1'b0, 5'd4);
        wait_drain("presc4");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
